bullet_scheduler: RTL and testbench
===================================

Name: bullet_scheduler

Overview:
Sequences a pool of NUM_SLOTS player bullet instances. Converts the raw fire button into at most one launch per frame and allocates each launch to a free slot by round-robin. Enforces a per-launch cooldown measured in frames and keeps shot and hit statistics. Sits between the input pins and the bullet slot array; slot_launch drives each slot's spawn input, and slot_active / slot_hit are returned from the slots and the collision logic.

Parameters:
NUM_SLOTS, 4, number of bullet slots managed (2..8)
COOLDOWN_FRAMES, 8, frames after a launch during which no new launch is issued (0 = none; max 255)
CNT_W, 16, width of the statistics counters
AMMO_MAX, 30, ammo reload value (only used with BULLET_AMMO_EN; 1..254)

Ports:
pixel_clk  in  1  pixel clock; sole clock
rst  in  1  synchronous, active-high reset
fsync  in  1  one-cycle frame-start strobe
fire  in  1  raw asynchronous fire button, active high
reload  in  1  one-cycle ammo refill request (ignored without BULLET_AMMO_EN)
slot_active  in  NUM_SLOTS  bit i = slot i bullet in flight
slot_hit  in  NUM_SLOTS  bit i = slot i bullet hit an alien this cycle
slot_launch  out  NUM_SLOTS  one-hot, one-cycle spawn pulse to the chosen slot
fire_pending  out  1  accepted fire request awaiting launch
cooldown_busy  out  1  cooldown counter nonzero
all_busy  out  1  every slot active (combinational AND of slot_active)
shots_fired  out  CNT_W  saturating launch count
hits  out  CNT_W  saturating hit count
ammo_left  out  8  remaining ammo

Behaviour:
- Reset values: slot_launch 0, fire_pending 0, cooldown counter 0, cooldown_busy 0, shots_fired 0, hits 0, rr_ptr 0, FSM READY, sync flops 0, ammo_left AMMO_MAX (8'hFF without macro).
- Input sync: fire passes through a 2-flop synchronizer plus an edge flop. A rising edge on the synchronized signal sets the pending latch. Minimum edge-to-fire_pending latency is 3 cycles. Holding the button gives one request only.
- FSM states: READY, PENDING, COOLDOWN.
  - READY -> PENDING on a sync'd rising edge.
  - PENDING -> launch on the first fsync cycle where a free slot exists (and ammo_left > 0 with the macro). Then go to COOLDOWN if COOLDOWN_FRAMES > 0, otherwise READY.
  - COOLDOWN: the counter decrements on each fsync. It is not decremented on the launch fsync itself. Move to READY when it reaches 0.
  - A fire edge during COOLDOWN sets fire_pending. The state goes to PENDING when the cooldown expires, so that fire is serviced at the next fsync.
- Additional fire edges while already pending are absorbed; there is no queue depth beyond 1.
- Launch timing: the decision is made in the fsync cycle. slot_launch is registered and high for exactly the one cycle after fsync. fire_pending clears in that same cycle. shots_fired increments in that same cycle and saturates at all-ones.
- Slot choice: first slot with slot_active=0, scanning upward from rr_ptr and wrapping modulo NUM_SLOTS. After a launch, rr_ptr = (granted index + 1) mod NUM_SLOTS.
- No free slot at fsync: no launch, request stays pending, cooldown is not reloaded. Retry at every later fsync.
- An fsync in the same cycle as the fire edge does not service that edge (sync latency). It is serviced at the next fsync.
- Hits: each cycle, hits += popcount(slot_hit & slot_active), saturating at all-ones. A hit on an inactive slot is ignored.
- rst asserted mid-operation (including the cycle of a launch pulse) returns everything to reset values on the next edge. The pending request is discarded.

Optional Feature:
BULLET_AMMO_EN:
- Defined:
  - ammo_left starts at AMMO_MAX and decrements by 1 per launch.
  - At 0, requests remain pending but never launch until refilled.
  - A reload pulse sets ammo_left to AMMO_MAX. If reload coincides with a launch, the reload wins (result is AMMO_MAX).
- Undefined: ammo_left is constant 8'hFF, reload is ignored, and there is no ammo gating.

Test Plan:
- Reset, fire edge at cycle 10, fsync at cycle 20 -> slot_launch=4'b0001 at cycle 21 only; shots_fired=1; cooldown_busy=1.
- Fire held high across 5 fsyncs with COOLDOWN_FRAMES=2 -> exactly 1 launch; a second edge after release launches at the 3rd fsync after the first launch, into slot 1.
- slot_active=4'b1111, fire edge -> no launch and fire_pending=1 across 3 fsyncs; set slot_active=4'b1011 -> next fsync gives slot_launch=4'b0100.
- slot_hit=4'b0110 with slot_active=4'b0111 for one cycle -> hits=2; slot_hit=4'b1000 with slot_active=0 -> hits unchanged. Preload hits to all-ones -> stays saturated.
- Fire edge and fsync in the same cycle -> no launch at that fsync; launch after the next fsync.
- BULLET_AMMO_EN, AMMO_MAX=2 -> 2 launches, ammo_left=0, third request stays pending; reload -> ammo_left=2 and the pending shot launches at the next fsync.

Source files
------------

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: turns the fire button into at most one launch per frame, round-robin slot allocation, frame cooldown, shot/hit stats.
// Optional ammo gating and reload with `define BULLET_AMMO_EN.
module bullet_scheduler #(
  parameter int NUM_SLOTS       = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int CNT_W           = 16,
  parameter int AMMO_MAX        = 30
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic                 fsync,
  input  logic                 fire,
  input  logic                 reload,
  input  logic [NUM_SLOTS-1:0] slot_active,
  input  logic [NUM_SLOTS-1:0] slot_hit,
  output logic [NUM_SLOTS-1:0] slot_launch,
  output logic                 fire_pending,
  output logic                 cooldown_busy,
  output logic                 all_busy,
  output logic [CNT_W-1:0]     shots_fired,
  output logic [CNT_W-1:0]     hits,
  output logic [7:0]           ammo_left
);
  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  typedef enum logic [1:0] {READY, PENDING, COOLDOWN} state_t;
  state_t               r_state;
  logic                 r_sync1, r_sync2, r_edge, r_pending;
  logic [7:0]           r_cd;
  logic [PW-1:0]        r_rr;
  logic [NUM_SLOTS-1:0] r_launch;
  logic [CNT_W-1:0]     r_shots, r_hits;
  logic                 w_rise, w_free, w_launch, w_ammo_ok;
  logic [NUM_SLOTS-1:0] w_rot, w_hv, w_onehot;
  logic [PW-1:0]        w_off, w_sel, w_nxt;
  logic [PW:0]          w_sum;
  logic [CNT_W:0]       w_hsum;
  assign w_rise = r_sync2 & ~r_edge;
  // Rotate so bit 0 is the slot at rr_ptr; the lowest zero is the next free slot.
  assign w_rot = NUM_SLOTS'({slot_active, slot_active} >> r_rr);
  always_comb begin
    w_off  = '0;
    w_free = 1'b0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--)
      if (!w_rot[k]) begin
        w_off  = PW'(k);
        w_free = 1'b1;
      end
  end
  assign w_sum    = {1'b0, r_rr} + {1'b0, w_off};
  assign w_sel    = (w_sum >= NUM_SLOTS[PW:0]) ? PW'(w_sum - NUM_SLOTS[PW:0]) : PW'(w_sum);
  assign w_nxt    = (w_sel == PW'(NUM_SLOTS - 1)) ? '0 : w_sel + 1'b1;
  assign w_onehot = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << w_sel;
  assign w_launch = (r_state == PENDING) & fsync & w_free & w_ammo_ok;
  assign w_hv     = slot_hit & slot_active;
  always_comb begin
    w_hsum = {1'b0, r_hits};
    for (int k = 0; k < NUM_SLOTS; k++)
      w_hsum = w_hsum + {{CNT_W{1'b0}}, w_hv[k]};
  end
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state   <= READY;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_edge    <= 1'b0;
      r_pending <= 1'b0;
      r_cd      <= '0;
      r_rr      <= '0;
      r_launch  <= '0;
      r_shots   <= '0;
      r_hits    <= '0;
    end else begin
      r_sync1  <= fire;
      r_sync2  <= r_sync1;
      r_edge   <= r_sync2;
      r_launch <= w_launch ? w_onehot : '0;
      r_hits   <= w_hsum[CNT_W] ? '1 : w_hsum[CNT_W-1:0];
      if (w_launch) begin
        r_rr    <= w_nxt;
        r_shots <= r_shots + {{(CNT_W-1){1'b0}}, ~&r_shots};
      end
      case (r_state)
        READY: if (w_rise) begin
          r_state   <= PENDING;
          r_pending <= 1'b1;
        end
        PENDING: if (w_launch) begin
          r_pending <= w_rise;
          r_cd      <= 8'(COOLDOWN_FRAMES);
          r_state   <= (COOLDOWN_FRAMES != 0) ? COOLDOWN : w_rise ? PENDING : READY;
        end
        COOLDOWN: begin
          if (w_rise) r_pending <= 1'b1;
          if (fsync) begin
            r_cd <= r_cd - 1'b1;
            if (r_cd <= 8'd1) r_state <= (r_pending | w_rise) ? PENDING : READY;
          end
        end
        default: r_state <= READY;
      endcase
    end
  end
`ifdef BULLET_AMMO_EN
  logic [7:0] r_ammo;
  // Reload outranks a coinciding launch.
  always_ff @(posedge pixel_clk) begin
    if (rst || reload) r_ammo <= 8'(AMMO_MAX);
    else if (w_launch) r_ammo <= r_ammo - 1'b1;
  end
  assign w_ammo_ok = |r_ammo;
  assign ammo_left = r_ammo;
`else
  logic w_unused;
  assign w_unused  = ^{reload, AMMO_MAX[7:0]};
  assign w_ammo_ok = 1'b1;
  assign ammo_left = 8'hFF;
`endif
  assign slot_launch   = r_launch;
  assign fire_pending  = r_pending;
  assign cooldown_busy = |r_cd;
  assign all_busy      = &slot_active;
  assign shots_fired   = r_shots;
  assign hits          = r_hits;
endmodule

// File: tb/tb_bullet_scheduler.sv
// tb_bullet_scheduler: directed self-checking bench for bullet_scheduler (4 slots, 2-frame cooldown, 3-bit counters, ammo 2).
module tb_bullet_scheduler;
  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1, fsync = 1'b0, fire = 1'b0, reload = 1'b0;
  logic [3:0] slot_active = '0, slot_hit = '0;
  logic [3:0] slot_launch;
  logic       fire_pending, cooldown_busy, all_busy;
  logic [2:0] shots_fired, hits;
  logic [7:0] ammo_left;
  int checks = 0, errors = 0;
  bullet_scheduler #(.NUM_SLOTS(4), .COOLDOWN_FRAMES(2), .CNT_W(3), .AMMO_MAX(2)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .fire(fire), .reload(reload),
    .slot_active(slot_active), .slot_hit(slot_hit), .slot_launch(slot_launch),
    .fire_pending(fire_pending), .cooldown_busy(cooldown_busy), .all_busy(all_busy),
    .shots_fired(shots_fired), .hits(hits), .ammo_left(ammo_left)
  );
  always #5 pixel_clk = ~pixel_clk;
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge pixel_clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; fire = 1'b0; fsync = 1'b0; reload = 1'b0; slot_active = '0; slot_hit = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask
  task automatic fsync_tick();
    fsync = 1'b1;
    tick(1);
    fsync = 1'b0;
  endtask
  task automatic press();
    fire = 1'b0;
    tick(3);
    fire = 1'b1;
    tick(3);
  endtask
  task automatic test_reset();
    logic [7:0] exp_ammo;
`ifdef BULLET_AMMO_EN
    exp_ammo = 8'd2;
`else
    exp_ammo = 8'hFF;
`endif
    do_reset();
    checks++; if (slot_launch !== 4'b0000) begin errors++; $display("FAIL reset_launch got %b want 0000", slot_launch); end
    checks++; if (fire_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", fire_pending); end
    checks++; if (cooldown_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", cooldown_busy); end
    checks++; if (shots_fired !== 3'd0 || hits !== 3'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", shots_fired, hits); end
    checks++; if (ammo_left !== exp_ammo) begin errors++; $display("FAIL reset_ammo got %0d want %0d", ammo_left, exp_ammo); end
  endtask
  task automatic test_basic_launch();
    do_reset();
    fire = 1'b1;
    tick(2);
    checks++; if (fire_pending !== 1'b0) begin errors++; $display("FAIL early_pending got %b want 0", fire_pending); end
    tick(1);
    checks++; if (fire_pending !== 1'b1) begin errors++; $display("FAIL latency_pending got %b want 1", fire_pending); end
    tick(5);
    checks++; if (slot_launch !== 4'b0000) begin errors++; $display("FAIL prefsync_launch got %b want 0000", slot_launch); end
    fsync_tick();
    checks++; if (slot_launch !== 4'b0001) begin errors++; $display("FAIL basic_launch got %b want 0001", slot_launch); end
    checks++; if (shots_fired !== 3'd1) begin errors++; $display("FAIL basic_shots got %0d want 1", shots_fired); end
    checks++; if (cooldown_busy !== 1'b1 || fire_pending !== 1'b0) begin errors++; $display("FAIL basic_state got busy=%b pend=%b want 1/0", cooldown_busy, fire_pending); end
    tick(1);
    checks++; if (slot_launch !== 4'b0000) begin errors++; $display("FAIL basic_pulse_width got %b want 0000", slot_launch); end
  endtask
  task automatic test_hold_and_cooldown();
    int extra;
    do_reset();
    fire = 1'b1;
    tick(3);
    fsync_tick();
    checks++; if (slot_launch !== 4'b0001) begin errors++; $display("FAIL hold_first got %b want 0001", slot_launch); end
    press();
    checks++; if (fire_pending !== 1'b1 || cooldown_busy !== 1'b1) begin errors++; $display("FAIL cd_pending got pend=%b busy=%b want 1/1", fire_pending, cooldown_busy); end
    fsync_tick();
    checks++; if (slot_launch !== 4'b0000) begin errors++; $display("FAIL cd_f1 got %b want 0000", slot_launch); end
    tick(2);
    fsync_tick();
    checks++; if (slot_launch !== 4'b0000 || cooldown_busy !== 1'b0 || fire_pending !== 1'b1) begin errors++; $display("FAIL cd_f2 got launch=%b busy=%b pend=%b want 0000/0/1", slot_launch, cooldown_busy, fire_pending); end
    tick(2);
    fsync_tick();
    checks++; if (slot_launch !== 4'b0010) begin errors++; $display("FAIL cd_f3 got %b want 0010", slot_launch); end
    extra = 0;
    for (int f = 0; f < 5; f++) begin
      tick(2);
      fsync_tick();
      if (slot_launch !== 4'b0000) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL hold_extra got %0d launches want 0", extra); end
    checks++; if (shots_fired !== 3'd2) begin errors++; $display("FAIL hold_shots got %0d want 2", shots_fired); end
  endtask
  task automatic test_all_busy();
    do_reset();
    slot_active = 4'b1111;
    press();
    for (int f = 0; f < 3; f++) begin
      fsync_tick();
      checks++; if (slot_launch !== 4'b0000 || fire_pending !== 1'b1) begin errors++; $display("FAIL full_f%0d got launch=%b pend=%b want 0000/1", f, slot_launch, fire_pending); end
      tick(2);
    end
    checks++; if (all_busy !== 1'b1 || cooldown_busy !== 1'b0) begin errors++; $display("FAIL full_flags got all=%b busy=%b want 1/0", all_busy, cooldown_busy); end
    slot_active = 4'b1011;
    #1;
    checks++; if (all_busy !== 1'b0) begin errors++; $display("FAIL all_busy_comb got %b want 0", all_busy); end
    fsync_tick();
    checks++; if (slot_launch !== 4'b0100) begin errors++; $display("FAIL full_free got %b want 0100", slot_launch); end
  endtask
  task automatic test_hits();
    do_reset();
    slot_hit = 4'b0110; slot_active = 4'b0111;
    tick(1);
    checks++; if (hits !== 3'd2) begin errors++; $display("FAIL hits_two got %0d want 2", hits); end
    slot_hit = 4'b1000; slot_active = 4'b0000;
    tick(1);
    checks++; if (hits !== 3'd2) begin errors++; $display("FAIL hits_inactive got %0d want 2", hits); end
    slot_hit = 4'b1111; slot_active = 4'b1111;
    tick(1);
    checks++; if (hits !== 3'd6) begin errors++; $display("FAIL hits_four got %0d want 6", hits); end
    tick(1);
    checks++; if (hits !== 3'd7) begin errors++; $display("FAIL hits_sat got %0d want 7", hits); end
    tick(1);
    checks++; if (hits !== 3'd7) begin errors++; $display("FAIL hits_hold got %0d want 7", hits); end
    slot_hit = '0; slot_active = '0;
  endtask
  task automatic test_same_cycle_fsync();
    do_reset();
    fire = 1'b1;
    tick(2);
    fsync_tick();
    checks++; if (slot_launch !== 4'b0000 || fire_pending !== 1'b1) begin errors++; $display("FAIL same_cycle got launch=%b pend=%b want 0000/1", slot_launch, fire_pending); end
    tick(3);
    fsync_tick();
    checks++; if (slot_launch !== 4'b0001) begin errors++; $display("FAIL same_cycle_next got %b want 0001", slot_launch); end
  endtask
  task automatic test_reset_midop();
    do_reset();
    press();
    fsync_tick();
    checks++; if (slot_launch !== 4'b0001) begin errors++; $display("FAIL mid_pre got %b want 0001", slot_launch); end
    rst = 1'b1; fire = 1'b0;
    tick(1);
    checks++; if (slot_launch !== 4'b0000 || shots_fired !== 3'd0 || cooldown_busy !== 1'b0) begin errors++; $display("FAIL mid_rst got launch=%b shots=%0d busy=%b want 0000/0/0", slot_launch, shots_fired, cooldown_busy); end
    rst = 1'b0;
    press();
    rst = 1'b1; fire = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    fsync_tick();
    checks++; if (slot_launch !== 4'b0000 || fire_pending !== 1'b0) begin errors++; $display("FAIL mid_discard got launch=%b pend=%b want 0000/0", slot_launch, fire_pending); end
  endtask
`ifdef BULLET_AMMO_EN
  task automatic test_ammo();
    do_reset();
    press();
    fsync_tick();
    checks++; if (ammo_left !== 8'd1) begin errors++; $display("FAIL ammo_one got %0d want 1", ammo_left); end
    fsync_tick(); tick(1); fsync_tick();
    press();
    fsync_tick();
    checks++; if (slot_launch !== 4'b0010 || ammo_left !== 8'd0) begin errors++; $display("FAIL ammo_two got launch=%b ammo=%0d want 0010/0", slot_launch, ammo_left); end
    fsync_tick(); tick(1); fsync_tick();
    press();
    fsync_tick();
    checks++; if (slot_launch !== 4'b0000 || fire_pending !== 1'b1) begin errors++; $display("FAIL ammo_empty got launch=%b pend=%b want 0000/1", slot_launch, fire_pending); end
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
    checks++; if (ammo_left !== 8'd2) begin errors++; $display("FAIL ammo_reload got %0d want 2", ammo_left); end
    fsync_tick();
    checks++; if (slot_launch !== 4'b0100 || ammo_left !== 8'd1) begin errors++; $display("FAIL ammo_after got launch=%b ammo=%0d want 0100/1", slot_launch, ammo_left); end
  endtask
`else
  task automatic test_ammo();
    do_reset();
    reload = 1'b1;
    press();
    reload = 1'b0;
    fsync_tick();
    checks++; if (slot_launch !== 4'b0001 || ammo_left !== 8'hFF) begin errors++; $display("FAIL noammo got launch=%b ammo=%0d want 0001/255", slot_launch, ammo_left); end
  endtask
`endif
  initial begin
    test_reset();
    test_basic_launch();
    test_hold_and_cooldown();
    test_all_busy();
    test_hits();
    test_same_cycle_fsync();
    test_reset_midop();
    test_ammo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
